mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter_pkg.sv | 30 +++
 rtl/mux_sel_arbiter_rr_pick4.sv | 33 +++
 rtl/mux_sel_arbiter.sv | 103 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter_pkg
// Purpose  : Shared constants, FSM state type and helpers for the
//            round-robin select arbiter that drives a 4:1 mux.
// Contents : N_REQ, SEL_W, CNT_W, HOLD_MAX_DEF, state_t, onehot_sel()
// Revision : 1.0 - initial release
// ============================================================================
package mux_sel_arbiter_pkg;

  localparam int N_REQ        = 4;
  localparam int SEL_W        = 2;
  localparam int CNT_W        = 8;
  localparam int HOLD_MAX_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Grant vector for a given select value.
  function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] s);
    logic [N_REQ-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational round-robin search over 4 requests. Returns the
//            first set request bit at or above ptr, wrapping modulo 4.
// Ports    : req    [3:0] in  - request vector
//            ptr    [1:0] in  - search start position
//            winner [1:0] out - index of the selected request (ptr if none)
//            any          out - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  assign any = |req;

  // Walk from the farthest position back toward ptr so the closest set bit
  // (in wrapped order) is the last assignment and therefore wins.
  always_comb begin
    winner = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Purpose  : Round-robin arbiter producing the select for a downstream 4:1
//            mux. A grant is held until the grantee signals done, drops its
//            request, or has held it for HOLD_MAX cycles. All outputs are
//            registered; sel can be wired straight to the mux sel port.
// Ports    : clk             in  - rising-edge clock
//            rst             in  - asynchronous active-high reset
//            req   [N_REQ-1] in  - per-source request
//            done            in  - current grantee releases the grant
//            sel   [1:0]     out - mux select (holds last value when idle)
//            gnt   [N_REQ-1] out - one-hot grant, zero when idle
//            gnt_valid       out - sel/gnt hold a live grant
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int N_REQ    = mux_sel_arbiter_pkg::N_REQ,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             release_now;

  // In GRANT the next winner is only consumed on release, where the search
  // starts just past the current grantee; this puts a timed-out grantee at
  // lowest priority. In IDLE the stored pointer is used.
  assign pick_ptr    = (state == ST_GRANT) ? sel + 2'd1 : ptr;
  assign release_now = done | ~req[sel] | (cnt == HOLD_LAST);

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // done is meaningless without a live grant and is ignored here.
          if (any) begin
            state     <= ST_GRANT;
            sel       <= winner;
            gnt       <= onehot_sel(winner);
            gnt_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            ptr <= sel + 2'd1;
            cnt <= '0;
            if (any) begin
              // Back-to-back handover, no idle cycle.
              sel <= winner;
              gnt <= onehot_sel(winner);
            end else begin
              state     <= ST_IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Purpose  : Self-checking bench for mux_sel_arbiter: directed scenarios and
//            randomized traffic compared against a grant-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;

  int n_checks;
  int n_errors;

  // Reference: who holds the grant, for how many cycles so far, and where
  // the next round-robin search starts.
  int m_valid;
  int m_sel;
  int m_ptr;
  int m_held;

  mux_sel_arbiter #(.N_REQ(4), .HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_valid = 0;
    m_sel   = 0;
    m_ptr   = 0;
    m_held  = 0;
  endfunction

  // Advance the reference by one clock edge with inputs r / d.
  function automatic void model_edge(input logic [3:0] r, input logic d);
    if (m_valid == 0) begin
      if (r != 4'b0) begin
        m_sel   = rr_first(r, m_ptr);
        m_valid = 1;
        m_held  = 1;
      end
    end else if (d || !r[m_sel] || m_held == HOLD) begin
      m_ptr = (m_sel + 1) % 4;
      if (r != 4'b0) begin
        m_sel  = rr_first(r, m_ptr);
        m_held = 1;
      end else begin
        m_valid = 0;
      end
    end else begin
      m_held++;
    end
  endfunction

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_valid != 0) ? (4'b0001 << m_sel) : 4'b0000;
    chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_vld"}, 32'(gnt_valid), 32'(m_valid));
  endtask

  task automatic step(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    model_edge(r, d);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    done = 1'b0;
    #1;
    model_reset();
    chk("rst_async_sel", 32'(sel), 32'd0);
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    chk("rst_async_vld", 32'(gnt_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    req  = 4'b0;
    done = 1'b0;
    model_reset();

    // Idle after reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "idle");

    // Skip to 1 from ptr 0, then done hands straight to 3.
    step(4'b1010, 1'b0, "r031a");
    chk("r031_sel1", 32'(sel), 32'd1);
    chk("r031_gnt1", 32'(gnt), 32'h2);
    step(4'b1010, 1'b1, "r031b");
    chk("r031_sel3", 32'(sel), 32'd3);
    chk("r031_gnt3", 32'(gnt), 32'h8);
    chk("r031_noidle", 32'(gnt_valid), 32'd1);

    // All requesting, no done: rotation in blocks of HOLD cycles.
    do_reset();
    for (int k = 0; k < 5 * HOLD; k++) begin
      step(4'b1111, 1'b0, "rot");
      chk("rot_seq", 32'(sel), 32'((k / HOLD) % 4));
    end

    // Sole requester re-granted after each timeout without a gap.
    do_reset();
    for (int k = 0; k < 3 * HOLD; k++) begin
      step(4'b0100, 1'b0, "solo");
      chk("solo_vld", 32'(gnt_valid), 32'd1);
      chk("solo_sel", 32'(sel), 32'd2);
    end

    // Grantee drops request with nobody else asking: idle, sel kept.
    step(4'b0000, 1'b0, "drop");
    chk("drop_vld", 32'(gnt_valid), 32'd0);
    chk("drop_sel", 32'(sel), 32'd2);
    // done while idle has no effect.
    step(4'b0000, 1'b1, "idle_done");

    // Asynchronous abort mid-grant on sel 3, then restart from ptr 0.
    do_reset();
    step(4'b1000, 1'b0, "g3a");
    step(4'b1000, 1'b0, "g3b");
    chk("g3_sel", 32'(sel), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_vld", 32'(gnt_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1001, 1'b0, "after_rst");
    chk("after_rst_sel", 32'(sel), 32'd0);

    // Randomized traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] r;
      logic       d;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) r = 4'b0;
      d = ($urandom_range(0, 7) == 0);
      step(r, d, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
